// File: rtl/mac_layer_sequencer.sv
// mac_layer_sequencer: drives the single-neuron INT8 MAC runner once per output neuron of a
// layer. It packs four signed INT8 results into each 32-bit word and writes that word to an
// output BRAM. The host sees one layer-level start/busy/done handshake.
//
// Optional build macro MAC_SEQ_RELU_EN: when it is defined, each result below the output zero
// point zo_in is clamped up to zo_in before packing (quantized ReLU). When it is undefined, the
// result is packed unchanged and zo_in is ignored.

module mac_layer_sequencer #(
    parameter int unsigned NEURON_W   = 10,
    parameter int unsigned OUT_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  layer_start_in,
    input  logic [NEURON_W-1:0]   num_neurons_in,
    input  logic [7:0]            zo_in,
    output logic                  runner_start_out,
    input  logic                  runner_done_in,
    input  logic [7:0]            runner_result_in,
    output logic [NEURON_W-1:0]   neuron_idx_out,
    output logic                  out_we,
    output logic [OUT_ADDR_W-1:0] out_addr,
    output logic [31:0]           out_wdata,
    output logic [3:0]            out_be,
    output logic                  layer_busy,
    output logic                  layer_done
);

    localparam logic [NEURON_W-1:0] IdxOne = NEURON_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StStore,
        StWrite,
        StDone
    } state_e;

    state_e                state_q;
    logic [NEURON_W-1:0]   count_q;
    logic [NEURON_W-1:0]   idx_q;
    logic [31:0]           pack_q;
    logic [3:0]            be_acc_q;
    logic [7:0]            result_q;
    logic                  start_d;
    logic                  done_d;

    logic                  start_pulse;
    logic                  done_rise;
    logic [1:0]            lane;
    logic                  last_neuron;
    logic                  word_full;
    logic [7:0]            relu_val;
    logic [31:0]           pack_next;
    logic [3:0]            be_next;
    logic [OUT_ADDR_W-1:0] word_addr;

    assign start_pulse    = layer_start_in & ~start_d;
    // The runner holds done high until its next start, so only a fresh rising edge is a result.
    assign done_rise      = runner_done_in & ~done_d;
    assign lane           = idx_q[1:0];
    assign last_neuron    = (idx_q == (count_q - IdxOne));
    assign word_full      = (lane == 2'd3);
    // Truncation gives the modulo-2^OUT_ADDR_W wrap when a layer overflows the output BRAM.
    assign word_addr      = OUT_ADDR_W'(idx_q[NEURON_W-1:2]);
    assign neuron_idx_out = idx_q;

    // Result post-processing: quantized ReLU clamps at the output zero point when enabled.
`ifdef MAC_SEQ_RELU_EN
    always_comb begin
        relu_val = result_q;
        if ($signed(result_q) < $signed(zo_in)) begin
            relu_val = zo_in;
        end
    end
`else
    logic unused_zo;
    assign unused_zo = ^zo_in;

    always_comb begin
        relu_val = result_q;
    end
`endif

    // Pack register and byte-enable accumulator with the current lane merged in.
    always_comb begin
        pack_next = pack_q;
        be_next   = be_acc_q;
        pack_next[{lane, 3'b000} +: 8] = relu_val;
        be_next[lane] = 1'b1;
    end

    // Edge-detect history for the host start and the runner done level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_d <= 1'b0;
            done_d  <= 1'b0;
        end else begin
            start_d <= layer_start_in;
            done_d  <= runner_done_in;
        end
    end

    // Layer FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= StIdle;
            count_q          <= '0;
            idx_q            <= '0;
            pack_q           <= '0;
            be_acc_q         <= '0;
            result_q         <= '0;
            runner_start_out <= 1'b0;
            out_we           <= 1'b0;
            out_addr         <= '0;
            out_wdata        <= '0;
            out_be           <= '0;
            layer_busy       <= 1'b0;
            layer_done       <= 1'b0;
        end else begin
            runner_start_out <= 1'b0;
            out_we           <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    // A start pulse that arrives while the layer is busy never reaches this branch.
                    if (start_pulse) begin
                        count_q    <= num_neurons_in;
                        idx_q      <= '0;
                        pack_q     <= '0;
                        be_acc_q   <= '0;
                        layer_done <= 1'b0;
                        if (num_neurons_in == '0) begin
                            state_q    <= StDone;
                            layer_done <= 1'b1;
                            layer_busy <= 1'b0;
                        end else begin
                            state_q          <= StIssue;
                            runner_start_out <= 1'b1;
                            layer_busy       <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (done_rise) begin
                        result_q <= runner_result_in;
                        state_q  <= StStore;
                    end
                end
                StStore: begin
                    pack_q   <= pack_next;
                    be_acc_q <= be_next;
                    if (word_full || last_neuron) begin
                        state_q   <= StWrite;
                        out_we    <= 1'b1;
                        out_addr  <= word_addr;
                        out_wdata <= pack_next;
                        out_be    <= be_next;
                    end else begin
                        idx_q            <= idx_q + IdxOne;
                        state_q          <= StIssue;
                        runner_start_out <= 1'b1;
                    end
                end
                StWrite: begin
                    pack_q    <= '0;
                    be_acc_q  <= '0;
                    out_addr  <= '0;
                    out_wdata <= '0;
                    out_be    <= '0;
                    if (last_neuron) begin
                        state_q    <= StDone;
                        layer_done <= 1'b1;
                        layer_busy <= 1'b0;
                    end else begin
                        idx_q            <= idx_q + IdxOne;
                        state_q          <= StIssue;
                        runner_start_out <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Self-checking bench for mac_layer_sequencer. A behavioural runner model answers start pulses.
// The expected BRAM writes are computed per layer from the list of results and queued.
// A monitor compares every out_we cycle against the head of that queue.

module tb_mac_layer_sequencer;

    localparam int NW = 10;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          layer_start_in = 1'b0;
    logic [NW-1:0] num_neurons_in = '0;
    logic [7:0]    zo_in = '0;
    logic          runner_done_in = 1'b0;
    logic [7:0]    runner_result_in = '0;
    logic          runner_start_out;
    logic [NW-1:0] neuron_idx_out;
    logic          out_we;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_wdata;
    logic [3:0]    out_be;
    logic          layer_busy;
    logic          layer_done;

    mac_layer_sequencer #(.NEURON_W(NW), .OUT_ADDR_W(AW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .layer_start_in   (layer_start_in),
        .num_neurons_in   (num_neurons_in),
        .zo_in            (zo_in),
        .runner_start_out (runner_start_out),
        .runner_done_in   (runner_done_in),
        .runner_result_in (runner_result_in),
        .neuron_idx_out   (neuron_idx_out),
        .out_we           (out_we),
        .out_addr         (out_addr),
        .out_wdata        (out_wdata),
        .out_be           (out_be),
        .layer_busy       (layer_busy),
        .layer_done       (layer_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
    } wr_t;

    int         total = 0;
    int         bad = 0;
    wr_t        exp_q[$];
    logic [7:0] res_q[$];
    int         lat_q[$];
    logic [7:0] stim[$];
    int         drop_delay = 0;
    int         starts_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_val(input logic [7:0] r, input logic [7:0] zo);
`ifdef MAC_SEQ_RELU_EN
        return ($signed(r) < $signed(zo)) ? zo : r;
`else
        return (zo == zo) ? r : r;
`endif
    endfunction

    // Runner model. A start drops done, optionally late, and after a latency the next result
    // is presented with done high. Done is then held high until the next start.
    initial begin
        int         lat_cnt;
        int         drop_cnt;
        bit         pending;
        logic [7:0] cur;
        lat_cnt = 0;
        drop_cnt = 0;
        pending = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                runner_done_in = 1'b0;
                pending = 1'b0;
                drop_cnt = 0;
            end else begin
                if (drop_cnt > 0) begin
                    drop_cnt--;
                    if (drop_cnt == 0) runner_done_in = 1'b0;
                end
                if (pending) begin
                    if (lat_cnt == 0) begin
                        runner_result_in = cur;
                        runner_done_in = 1'b1;
                        pending = 1'b0;
                    end else begin
                        lat_cnt--;
                    end
                end
                if (runner_start_out) begin
                    check("start_neuron_idx", 32'(neuron_idx_out), 32'(starts_seen));
                    starts_seen++;
                    if (res_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_runner_start: idx 0x%0h, no result left", neuron_idx_out);
                    end else begin
                        cur = res_q.pop_front();
                        lat_cnt = lat_q.pop_front();
                        pending = 1'b1;
                        if (drop_delay == 0) runner_done_in = 1'b0;
                        else drop_cnt = drop_delay;
                    end
                end
            end
        end
    end

    // Write monitor: every out_we cycle must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (out_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h be 0x%0h", out_addr,
                             out_wdata, out_be);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(out_addr), 32'(e.addr));
                    check("write_data", out_wdata, e.data);
                    check("write_be", 32'(out_be), 32'(e.be));
                end
            end
        end
    end

    // Queue up the layer in stim[], start it and wait for it to finish under a cycle bound.
    task automatic run_layer(input int lat_lo, input int lat_hi, input int drop, input bit extra);
        int  n;
        int  bound;
        wr_t w;
        n = stim.size();
        drop_delay = drop;
        starts_seen = 0;
        for (int i = 0; i < n; i++) begin
            res_q.push_back(stim[i]);
            lat_q.push_back(int'($urandom_range(lat_hi, lat_lo)));
        end
        // Expected words: groups of four consecutive results; unused lanes zero and disabled.
        for (int wi = 0; wi * 4 < n; wi++) begin
            w.addr = AW'(wi);
            w.data = '0;
            w.be = '0;
            for (int l = 0; l < 4; l++) begin
                if (wi * 4 + l < n) begin
                    w.data[8*l +: 8] = ref_val(stim[wi*4 + l], zo_in);
                    w.be[l] = 1'b1;
                end
            end
            exp_q.push_back(w);
        end
        @(negedge clk);
        num_neurons_in = NW'(n);
        layer_start_in = 1'b1;
        @(negedge clk);
        layer_start_in = 1'b0;
        num_neurons_in = NW'($urandom);
        if (n > 0) begin
            check("busy_after_start", 32'(layer_busy), 32'd1);
            check("done_cleared", 32'(layer_done), 32'd0);
        end
        if (extra) begin
            repeat (3) @(negedge clk);
            check("busy_before_restart", 32'(layer_busy), 32'd1);
            num_neurons_in = NW'(n + 5);
            layer_start_in = 1'b1;
            @(negedge clk);
            layer_start_in = 1'b0;
        end
        bound = (n == 0) ? 2 : n * (lat_hi + 8) + 10;
        for (int c = 0; c < bound; c++) begin
            if (layer_done) break;
            @(negedge clk);
        end
        check("layer_done", 32'(layer_done), 32'd1);
        check("layer_idle", 32'(layer_busy), 32'd0);
        repeat (3) @(negedge clk);
        check("runner_starts", 32'(starts_seen), 32'(n));
        check("missing_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        res_q.delete();
        lat_q.delete();
        stim.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 32'(runner_start_out), 32'd0);
        check({tag, "_we"}, 32'(out_we), 32'd0);
        check({tag, "_addr"}, 32'(out_addr), 32'd0);
        check({tag, "_wdata"}, out_wdata, 32'd0);
        check({tag, "_be"}, 32'(out_be), 32'd0);
        check({tag, "_idx"}, 32'(neuron_idx_out), 32'd0);
        check({tag, "_busy"}, 32'(layer_busy), 32'd0);
        check({tag, "_done"}, 32'(layer_done), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        // Four neurons with a 20-cycle runner; expected word 0x7F07FD0A, all bytes enabled.
        stim = '{8'h0A, 8'hFD, 8'h07, 8'h7F};
        run_layer(20, 20, 0, 1'b0);

        // Six neurons: one full word, then a partial word with two lanes.
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_layer(3, 8, 0, 1'b0);

        // Empty layer: done with no runner activity and no writes.
        run_layer(3, 3, 0, 1'b0);

        // Done still high after the start; the stale level carries the old result.
        stim = '{8'h11, 8'h22, 8'h33};
        run_layer(15, 15, 2, 1'b0);

        // A second start while busy is ignored.
        stim = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hE5};
        run_layer(10, 14, 1, 1'b1);

        // Reset in the middle of the layer, during the wait for the second neuron.
        drop_delay = 0;
        starts_seen = 0;
        for (int i = 0; i < 8; i++) begin
            res_q.push_back(8'($urandom));
            lat_q.push_back(12);
        end
        @(negedge clk);
        num_neurons_in = NW'(8);
        layer_start_in = 1'b1;
        @(negedge clk);
        layer_start_in = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (starts_seen >= 2) break;
            @(negedge clk);
        end
        check("starts_before_reset", 32'(starts_seen), 32'd2);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        res_q.delete();
        lat_q.delete();
        repeat (3) @(negedge clk);
        check("no_restart_in_reset", 32'(starts_seen), 32'd2);
        rstn = 1'b1;
        stim = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        run_layer(3, 6, 0, 1'b0);

`ifdef MAC_SEQ_RELU_EN
        // Clamp at zo = -5: expected word 0xFB03FBFB.
        zo_in = 8'hFB;
        stim = '{8'hEC, 8'hFB, 8'h03, 8'h80};
        run_layer(4, 6, 0, 1'b0);
`endif

        // Random layers.
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(13, 1));
            zo_in = 8'($urandom);
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
            run_layer(3, 10, int'($urandom_range(2, 0)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_layer_sequencer.md
Name: mac_layer_sequencer

Overview:
- Sits directly downstream of, and controls, the single-neuron INT8 MAC runner.
- Runs one runner job per output neuron of a layer and exposes the current neuron index, which upstream logic uses to select bias/M0/BRAM bank.
- Captures each signed INT8 result, optionally applies ReLU, packs four results per 32-bit word and writes the words to an output BRAM.
- Gives the host a single layer-level start/busy/done handshake.

Parameters:
- NEURON_W, 10: width of the neuron count and neuron index.
- OUT_ADDR_W, 8: output BRAM word-address width. Must be at least NEURON_W-2.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- layer_start_in  in  1  layer start; rising-edge detected
- num_neurons_in  in  NEURON_W  neurons in the layer; sampled at start
- zo_in  in  8  signed output zero point; used only by the ReLU feature
- runner_start_out  out  1  one-cycle start pulse to the runner
- runner_done_in  in  1  runner done level, held until the runner's next start
- runner_result_in  in  8  signed runner result, valid while done is high
- neuron_idx_out  out  NEURON_W  index of the neuron currently being processed
- out_we  out  1  output BRAM write enable, one cycle per word
- out_addr  out  OUT_ADDR_W  word address, equal to neuron_idx>>2
- out_wdata  out  32  packed results; lane k occupies bits [8k+7:8k], lane = idx[1:0]
- out_be  out  4  byte enables
- layer_busy  out  1  high in every state except IDLE and DONE
- layer_done  out  1  sticky; cleared by the next accepted start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pack register, byte-enable accumulator, count, start_d and done_d all 0.
- Edge detection:
  - start_pulse = layer_start_in & ~start_d.
  - done_rise = runner_done_in & ~done_d.
  - Only done_rise captures a result. This is required because the runner holds done high until it sees the next start.
- FSM states: IDLE, ISSUE, WAIT, STORE, WRITE, DONE.
- IDLE / DONE on start_pulse:
  - Latch num_neurons_in into count and set idx=0.
  - Clear layer_done, the pack register and the byte-enable accumulator.
  - If count==0: go to DONE with layer_done=1 and perform no writes. Otherwise go to ISSUE.
- ISSUE:
  - Assert runner_start_out for exactly one cycle; go to WAIT.
  - neuron_idx_out is stable from ISSUE until STORE exits.
- WAIT:
  - Hold until done_rise, then register runner_result_in and go to STORE.
  - A done level that is already high from the previous neuron must not trigger capture.
- STORE:
  - Write the (ReLU-processed) result into lane idx[1:0] of the pack register and set the matching byte-enable bit.
  - If idx[1:0]==3 or idx==count-1: go to WRITE.
  - Otherwise: idx<=idx+1 and go to ISSUE.
- WRITE:
  - One cycle with out_we=1, out_addr=idx>>2, out_wdata=pack register, out_be=accumulator.
  - Then clear the pack register and accumulator.
  - If idx==count-1: go to DONE with layer_done=1. Otherwise: idx<=idx+1 and go to ISSUE.
  - A partial final word has its unused lanes at 0 and their out_be bits at 0.
- Writes are registered outputs; out_we is never high outside WRITE.
- Minimum per-neuron overhead over the runner latency: ISSUE+STORE = 2 cycles, plus 1 cycle for WRITE on word boundaries.
- start_pulse while busy is ignored. num_neurons_in changes after start have no effect.
- runner_done_in rising outside WAIT is ignored.
- Reset mid-layer: immediate return to reset values. No write is completed and the runner is not restarted.
- out_addr wraps modulo 2^OUT_ADDR_W if the count exceeds capacity. No error flag.

Optional Feature:
- Macro: MAC_SEQ_RELU_EN.
- Defined: in STORE, a result (signed) less than zo_in is replaced by zo_in before packing, i.e. quantized ReLU.
- Undefined: the result is packed unchanged and zo_in is unused.

Test Plan:
- num_neurons=4, runner model returns 10,-3,7,127 after 20 cycles each:
  - exactly 4 runner_start_out pulses;
  - one write at addr 0, wdata 0x7F07FD0A, be 4'hF;
  - layer_done=1, layer_busy=0 afterwards.
- num_neurons=6, results 1..6:
  - writes addr0=0x04030201 with be F;
  - addr1=0x00000605 with be 4'h3;
  - no third write.
- num_neurons=0: no runner_start_out, no out_we; layer_done=1 two cycles after start.
- runner_done_in held high between neurons; second result delayed 15 cycles: no capture until the new done rising edge; the captured value is the new result.
- Second layer_start pulse while busy: ignored, start count unchanged. rstn low in WAIT of neuron 2: all outputs 0 immediately, no write; a new start then runs the layer cleanly.
- MAC_SEQ_RELU_EN with zo=-5 and results -20,-5,3,-128: packed word 0xFB03FBFB.
